// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port among N_REQ valid/ready
// producers, with bounded bursts and isFull back-pressure.
module fifo_wr_arbiter #(
  parameter int D_WIDTH   = 8,
  parameter int N_REQ     = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ-1:0]           req_last,
  input  logic [N_REQ*D_WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]           req_ready,
  input  logic                       fifo_isFull,
  output logic                       fifo_w_en,
  output logic [D_WIDTH-1:0]         fifo_w_data,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       busy
);
  localparam int GW = $clog2(N_REQ);
  localparam int BW = $clog2(MAX_BURST) + 1;
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;
  logic [0:0]    state;
  logic [GW-1:0] rr_ptr;
  logic [GW-1:0] pick;
  logic [BW-1:0] beat_cnt;
  logic          beat;
  logic          release_g;
  int            idx;
  // Scan downward so the lowest offset from rr_ptr is the last (winning) assignment.
  always_comb begin
    pick = rr_ptr;
    idx  = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % N_REQ;
      if (req_valid[idx]) pick = GW'(idx);
    end
  end
  assign busy        = state == GRANT;
  assign beat        = !rst && busy && req_valid[grant_id] && !fifo_isFull;
  assign release_g   = busy && (!req_valid[grant_id] ||
                       (beat && (req_last[grant_id] || beat_cnt == BW'(MAX_BURST - 1))));
  assign fifo_w_en   = beat;
  assign fifo_w_data = beat ? req_data[int'(grant_id)*D_WIDTH +: D_WIDTH] : '0;
  assign req_ready   = beat ? N_REQ'(1) << grant_id : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grant_id <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else if (state == IDLE) begin
      if (|req_valid) begin
        grant_id <= pick;
        beat_cnt <= '0;
        state    <= GRANT;
      end
    end else begin
      if (beat) beat_cnt <= beat_cnt + 1'b1;
      if (release_g) begin
        rr_ptr <= grant_id == GW'(N_REQ - 1) ? '0 : grant_id + 1'b1;
        state  <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed and randomized checks of fifo_wr_arbiter against a
// behavioural owner/pointer model, including a depth-8 FIFO occupancy model.
module tb_fifo_wr_arbiter;
  localparam int DW = 8;
  localparam int NR = 4;
  localparam int MB = 4;
  logic clk = 1'b0;
  logic rst;
  logic [NR-1:0] req_valid, req_last, req_ready;
  logic [NR*DW-1:0] req_data;
  logic fifo_isFull, fifo_w_en, busy;
  logic [DW-1:0] fifo_w_data;
  logic [1:0] grant_id;
  always #5 clk = ~clk;
  fifo_wr_arbiter #(.D_WIDTH(DW), .N_REQ(NR), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
    .req_ready(req_ready), .fifo_isFull(fifo_isFull), .fifo_w_en(fifo_w_en),
    .fifo_w_data(fifo_w_data), .grant_id(grant_id), .busy(busy)
  );
  int total = 0;
  int bad = 0;
  int m_own = -1;
  int m_gid = 0;
  int m_ptr = 0;
  int m_cnt = 0;
  int fifo_cnt = 0;
  int cyc = 0;
  bit use_fifo = 0;
  logic [7:0] nxt [NR];
  logic [7:0] wq [$];
  int gq [$];
  int wcyc [$];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic step(input logic [NR-1:0] v, input logic [NR-1:0] l, input bit f, input bit r, input bit rd);
    bit beat, full;
    int j;
    @(negedge clk);
    full = use_fifo ? (fifo_cnt >= 8) : f;
    rst = r;
    req_valid = v;
    req_last = l;
    fifo_isFull = full;
    for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = nxt[i];
    #1;
    beat = !r && m_own >= 0 && v[m_own] && !full;
    chk("w_en", fifo_w_en, beat);
    chk("w_data", fifo_w_data, beat ? nxt[m_own] : 0);
    chk("ready", req_ready, beat ? (1 << m_own) : 0);
    chk("busy", busy, m_own >= 0);
    chk("grant_id", grant_id, m_gid);
    if (fifo_w_en) begin
      wq.push_back(fifo_w_data);
      gq.push_back(int'(grant_id));
      wcyc.push_back(cyc);
    end
    if (use_fifo) fifo_cnt += (fifo_w_en ? 1 : 0) - ((rd && fifo_cnt > 0) ? 1 : 0);
    j = 0;
    if (r) begin
      m_own = -1; m_gid = 0; m_ptr = 0; m_cnt = 0;
    end else if (m_own < 0) begin
      if (|v) begin
        for (int k = 0; k < NR; k++) begin
          j = (m_ptr + k) % NR;
          if (v[j]) break;
        end
        m_own = j; m_gid = j; m_cnt = 0;
      end
    end else begin
      if (beat) begin
        m_cnt++;
        nxt[m_own]++;
      end
      if (!v[m_own] || (beat && (l[m_own] || m_cnt == MB))) begin
        m_ptr = (m_own + 1) % NR;
        m_own = -1;
      end
    end
    cyc++;
  endtask
  task automatic do_reset(input logic [NR-1:0] v);
    step(v, '0, 0, 1, 0);
    step(v, '0, 0, 1, 0);
    wq.delete(); gq.delete(); wcyc.delete();
  endtask
  initial begin
    rst = 1'b1; req_valid = '0; req_last = '0; req_data = '0; fifo_isFull = 1'b0;
    for (int i = 0; i < NR; i++) nxt[i] = 8'(i * 64);
    // reset with all requesters valid, then first grant must be requester 0
    do_reset('1);
    step('1, '1, 0, 0, 0);
    step('1, '1, 0, 0, 0);
    chk("first_grant", gq.size() > 0 ? gq[0] : -1, 0);
    // single requester: 4-beat burst, one bubble, then the remaining 2 beats
    do_reset('0);
    nxt[2] = 8'd5;
    repeat (8) step(4'b0100, '0, 0, 0, 0);
    step('0, '0, 0, 0, 0);
    chk("single_count", wq.size(), 6);
    for (int i = 0; i < 6 && i < wq.size(); i++) begin
      chk("single_data", wq[i], 5 + i);
      chk("single_gid", gq[i], 2);
    end
    if (wcyc.size() >= 5) chk("single_bubble", wcyc[4] - wcyc[3], 2);
    // round robin with 1-beat packets
    do_reset('0);
    repeat (16) step('1, '1, 0, 0, 0);
    chk("rr_count", wq.size(), 8);
    for (int i = 0; i < wq.size(); i++) begin
      chk("rr_order", gq[i], i % NR);
      if (i > 0) chk("rr_spacing", wcyc[i] - wcyc[i-1], 2);
    end
    // back-pressure mid-burst
    do_reset('0);
    nxt[1] = 8'h10;
    step(4'b0010, '0, 0, 0, 0);
    step(4'b0010, '0, 0, 0, 0);
    repeat (3) step(4'b0010, '0, 1, 0, 0);
    repeat (3) step(4'b0010, '0, 0, 0, 0);
    step('0, '0, 0, 0, 0);
    chk("bp_count", wq.size(), 4);
    if (wcyc.size() == 4) chk("bp_gap", wcyc[1] - wcyc[0], 4);
    // withdraw after 2 beats; pointer moves to 0
    do_reset('0);
    repeat (3) step(4'b1000, '0, 0, 0, 0);
    step(4'b0011, '0, 0, 0, 0);
    step(4'b0011, '0, 0, 0, 0);
    step(4'b0011, '0, 0, 0, 0);
    chk("wd_count", wq.size(), 3);
    if (gq.size() == 3) chk("wd_next", gq[2], 0);
    // integration with a depth-8 FIFO occupancy model
    do_reset('0);
    use_fifo = 1;
    fifo_cnt = 0;
    nxt[0] = 8'd0;
    nxt[1] = 8'd100;
    repeat (30) step({2'b00, nxt[1] < 8'd110, nxt[0] < 8'd10}, '0, 0, 0, 0);
    chk("int_writes", wq.size(), 8);
    chk("int_full", fifo_isFull, 1);
    repeat (3) step({2'b00, nxt[1] < 8'd110, nxt[0] < 8'd10}, '0, 0, 0, 1);
    repeat (10) step({2'b00, nxt[1] < 8'd110, nxt[0] < 8'd10}, '0, 0, 0, 0);
    chk("int_after_read", wq.size(), 11);
    use_fifo = 0;
    // randomized traffic with occasional reset
    do_reset('0);
    repeat (3000) step(NR'($urandom), NR'($urandom & $urandom), ($urandom % 5) == 0, ($urandom % 100) == 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that shares the single write port of the synchronous FIFO (`syn_FIFO`) among `N_REQ` independent producers. Each producer presents a valid/ready stream. The arbiter grants one producer at a time for a bounded burst and drives the FIFO's `w_en`/`w_data` directly. It respects `isFull` back-pressure and guarantees fair, starvation-free access. It sits between the producer blocks and `syn_FIFO`; the FIFO read side is untouched.

## Interface
- `D_WIDTH`, 8, data width; matches the FIFO `d_width`.
- `N_REQ`, 4, number of requesters (2..8).
- `MAX_BURST`, 4, maximum beats per grant (1..16).
- `clk`  in  1  clock; all logic updates on the rising edge.
- `rst`  in  1  reset. Synchronous, active-high; one clock; reset is synchronous and active-high.
- `req_valid`  in  N_REQ  bit i: requester i has a beat on its `req_data` slice.
- `req_last`  in  N_REQ  bit i: the current beat of requester i ends its packet.
- `req_data`  in  N_REQ*D_WIDTH  requester i data occupies bits [i*D_WIDTH +: D_WIDTH].
- `req_ready`  out  N_REQ  bit i: a beat is accepted from requester i this cycle.
- `fifo_isFull`  in  1  FIFO full flag.
- `fifo_w_en`  out  1  FIFO write enable.
- `fifo_w_data`  out  D_WIDTH  FIFO write data.
- `grant_id`  out  clog2(N_REQ)  index of the currently or last granted requester.
- `busy`  out  1  high while in the GRANT state.

## Operation
- There are two states, IDLE and GRANT. Registered state: `state`, `grant_id`, `rr_ptr` (next priority index), `beat_cnt` (width clog2(MAX_BURST)+1).

**IDLE**
- If any `req_valid` bit is set, select the first set index searching upward from `rr_ptr`, wrapping modulo N_REQ.
- Register that index into `grant_id`, clear `beat_cnt`, and go to GRANT.
- If no bit is set, stay in IDLE.
- No writes occur in IDLE: `req_ready` is 0 and `fifo_w_en` is 0.

**GRANT**
- Let g = `grant_id`. A beat occurs when `req_valid[g]` and not `fifo_isFull`.
- On a beat:
  - `fifo_w_en` = 1, `fifo_w_data` = the slice of g, `req_ready[g]` = 1.
  - All other `req_ready` bits are always 0.
- The outputs above are combinational from registered state plus current inputs. There are no registered data stages.
- On a beat, `beat_cnt` increments.
- Release the grant when any of the following holds:
  - a beat occurs with `req_last[g]` = 1;
  - a beat occurs with `beat_cnt` == MAX_BURST-1;
  - `req_valid[g]` = 0 (the requester withdrew or was idle).
- On release: `rr_ptr` <= (g+1) mod N_REQ, then go to IDLE.
- When `fifo_isFull` = 1: stall. No beat, grant held, `beat_cnt` unchanged, no release.
- When `fifo_isFull` = 1 and `req_valid[g]` = 0 in the same cycle, release still applies.

**Invariants**
- `fifo_w_en` is never 1 while `fifo_isFull` = 1.
- At most one `req_ready` bit is set, and it is set only together with `fifo_w_en`.
- Producers must hold `req_data`/`req_last` stable while `req_valid` = 1 and `req_ready` = 0.

## Timing
- Reset (`rst` high at an edge) sets state = IDLE, `grant_id` = 0, `rr_ptr` = 0, `beat_cnt` = 0, `busy` = 0.
- While `rst` is high, `fifo_w_en` = 0, `req_ready` = 0 and `fifo_w_data` = 0 combinationally, regardless of inputs.
- Reset mid-burst drops the grant immediately. No partial bookkeeping is retained.
- Arbitration latency: `req_valid` first sampled high in IDLE at edge t → GRANT from t; the first beat can be written in the cycle following edge t. `fifo_w_en` is seen by the FIFO at edge t+1.
- Each grant costs one IDLE bubble cycle. Sustained throughput is MAX_BURST beats per MAX_BURST+1 cycles with no back-pressure.
- Fairness: after requester g is released, every other continuously valid requester is granted before g again. Worst-case wait is (N_REQ-1)·(MAX_BURST+1) cycles plus stall cycles.
- `fifo_isFull` is sampled combinationally in the same cycle as the write. It is the FIFO's registered flag, so there is no write-after-full race.

## Test plan
- **Reset:** hold `rst` for 2 cycles with all `req_valid` = 1 → `fifo_w_en`, `req_ready`, `busy`, `grant_id` are all 0; after release, the first grant goes to 0.
- **Single requester:** only requester 2 valid with data 5,6,7,8,9,10 and no last → writes 5,6,7,8, then one bubble, then 9,10. `grant_id` = 2 throughout.
- **Round-robin:** all 4 valid continuously, each sending 1-beat packets (`req_last` = 1) → grant order 0,1,2,3,0,… with one write every 2 cycles.
- **Back-pressure:** requester 1 granted, `fifo_isFull` forced high for 3 cycles mid-burst → `fifo_w_en` = 0 for those 3 cycles, grant and `beat_cnt` held, and 4 total beats are written after the full flag clears.
- **Withdraw:** requester 3 granted, drops `req_valid` after 2 beats → release, `rr_ptr` = 0, and requester 0 is granted next if valid.
- **Integration with `syn_FIFO` (depth 8):** 2 requesters stream 10 beats each with no reads → exactly 8 writes accepted, `isFull` = 1, no write while full. Then read 3 → the next 3 beats are written in round-robin order, and data matches the requester sources.
